// File: rtl/wm_embed_ctrl.sv
// Frame-level watermark embedding controller: LFSR-keyed LSB substitution
// on a valid/ready pixel stream, advancing the watermark once per accepted pixel.
module wm_embed_ctrl #(
    parameter logic [7:0]  KEY          = 8'h6A,
    parameter logic [15:0] FRAME_PIXELS = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        WM_select,
    input  logic        s_valid,
    input  logic [7:0]  s_pixel,
    output logic        s_ready,
    output logic        m_valid,
    output logic [7:0]  m_pixel,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] pix_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_pixel_q, m_pixel_d;

    logic        s_ready_c;
    logic        in_hs;
    logic        out_hs;
    logic        w0;
    logic        w1;
    logic [7:0]  lfsr_adv;
    logic [7:0]  wm_pix;
    logic [15:0] cnt_inc;

    // Galois step: bit 7 wraps to bit 0 and feeds taps at bits 2/3/4
    always_comb begin
        lfsr_adv[0] = lfsr_q[7];
        lfsr_adv[1] = lfsr_q[0];
        lfsr_adv[2] = lfsr_q[1] ^ lfsr_q[7];
        lfsr_adv[3] = lfsr_q[2] ^ lfsr_q[7];
        lfsr_adv[4] = lfsr_q[3] ^ lfsr_q[7];
        lfsr_adv[5] = lfsr_q[4];
        lfsr_adv[6] = lfsr_q[5];
        lfsr_adv[7] = lfsr_q[6];
    end

    assign w0 = lfsr_q[0];
    assign w1 = lfsr_q[1] ^ lfsr_q[0];
    assign wm_pix = mode_q ? {s_pixel[7:2], w1, w0}
                           : {s_pixel[7:1], w0};

    assign in_hs   = s_valid && s_ready_c;
    assign out_hs  = m_valid_q && m_ready;
    assign cnt_inc = pix_cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lfsr_d    = lfsr_q;
        pix_cnt_d = pix_cnt_q;
        m_valid_d = m_valid_q;
        m_pixel_d = m_pixel_q;
        s_ready_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = WM_select;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                lfsr_d    = (KEY == 8'h00) ? 8'h01 : KEY;
                pix_cnt_d = 16'd0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                s_ready_c = (!m_valid_q || m_ready)
                         && (pix_cnt_q < FRAME_PIXELS);
                if (in_hs) begin
                    m_pixel_d = wm_pix;
                    m_valid_d = 1'b1;
                    pix_cnt_d = cnt_inc;
                    lfsr_d    = lfsr_adv;
                    if (cnt_inc == FRAME_PIXELS) begin
                        state_d = S_DRAIN;
                    end
                end else if (out_hs) begin
                    m_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            lfsr_q    <= KEY;
            pix_cnt_q <= 16'd0;
            m_valid_q <= 1'b0;
            m_pixel_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lfsr_q    <= lfsr_d;
            pix_cnt_q <= pix_cnt_d;
            m_valid_q <= m_valid_d;
            m_pixel_q <= m_pixel_d;
        end
    end

    assign s_ready = s_ready_c;
    assign m_valid = m_valid_q;
    assign m_pixel = m_pixel_q;
    assign pix_cnt = pix_cnt_q;
    assign busy    = (state_q == S_SEED) || (state_q == S_RUN)
                  || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_wm_embed_ctrl.sv
// Bench for wm_embed_ctrl: vector table, randomized backpressure
// scoreboard, and a second instance for the 1-pixel / zero-key corner.
module tb_wm_embed_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        WM_select;
    logic        s_valid;
    logic [7:0]  s_pixel;
    logic        m_ready;

    logic        s_ready, m_valid, busy, done;
    logic [7:0]  m_pixel;
    logic [15:0] pix_cnt;

    logic        b_s_ready, b_m_valid, b_busy, b_done;
    logic [7:0]  b_m_pixel;
    logic [15:0] b_pix_cnt;

    int n_chk;
    int n_pass;

    wm_embed_ctrl #(.KEY(8'h6A), .FRAME_PIXELS(16'd16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .WM_select(WM_select), .s_valid(s_valid),
        .s_pixel(s_pixel), .s_ready(s_ready),
        .m_valid(m_valid), .m_pixel(m_pixel),
        .m_ready(m_ready), .busy(busy), .done(done),
        .pix_cnt(pix_cnt)
    );

    wm_embed_ctrl #(.KEY(8'h00), .FRAME_PIXELS(16'd1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .WM_select(WM_select), .s_valid(s_valid),
        .s_pixel(s_pixel), .s_ready(b_s_ready),
        .m_valid(b_m_valid), .m_pixel(b_m_pixel),
        .m_ready(m_ready), .busy(b_busy), .done(b_done),
        .pix_cnt(b_pix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the watermark register is the key times x^n in
    // GF(2^8) modulo x^8+x^4+x^3+x^2+1 (mask 0x1D).
    function automatic logic [7:0] seed_of(input logic [7:0] k);
        return (k == 8'h00) ? 8'h01 : k;
    endfunction

    function automatic logic [7:0] mul_x(input logic [7:0] q);
        logic [8:0] t;
        t = {q, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0];
    endfunction

    function automatic logic [7:0] embed(input logic [7:0] p,
                                         input logic m,
                                         input logic [7:0] q);
        logic [7:0] r;
        int nb;
        nb = m ? 2 : 1;
        r = p;
        r[0] = q[0];
        if (nb == 2) r[1] = q[1] ^ q[0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        WM_select = 1'b0;
        s_valid = 1'b0;
        s_pixel = 8'h00;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        WM_select = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        WM_select = ~m;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_pixel = p;
        for (int k = 0; k < 50; k++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("s_ready_wait", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    typedef struct {
        bit         restart;
        bit         mode;
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] q;
        logic [7:0] expq[$];
        logic [7:0] e;
        bit mode_r;
        bit hold;
        logic [7:0] hold_pix;
        int n_done, n_out, last_out, done_cyc, after;
        bit done_seen;

        n_chk = 0;
        n_pass = 0;

        tbl[0] = '{1'b1, 1'b1, 8'h00, 8'h02};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 8'hFC};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h03};
        tbl[3] = '{1'b1, 1'b0, 8'hFF, 8'hFE};
        tbl[4] = '{1'b0, 1'b0, 8'hFF, 8'hFE};
        tbl[5] = '{1'b0, 1'b0, 8'hFF, 8'hFF};

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        WM_select = 1'b1;
        s_valid = 1'b0;
        s_pixel = 8'h00;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
        chk("rst_m_pixel", 32'(m_pixel), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        // Table-driven sequences
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].restart) begin
                do_reset();
                do_start(tbl[i].mode);
                chk("run_busy", 32'(busy), 32'd1);
            end
            send(tbl[i].pix);
            chk($sformatf("vec%0d_pixel", i), 32'(m_pixel),
                32'(tbl[i].exp));
            chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'd1);
        end
        chk("vec_pix_cnt", 32'(pix_cnt), 32'd3);

        // Randomized backpressure over a full 16-pixel frame
        do_reset();
        mode_r = 1'($urandom_range(0, 1));
        do_start(mode_r);
        q = seed_of(8'h6A);
        hold = 1'b0;
        hold_pix = 8'h00;
        n_done = 0;
        n_out = 0;
        last_out = -10;
        done_cyc = -1;
        done_seen = 1'b0;
        after = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_pixel = 8'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_pixel", 32'(m_pixel), 32'(hold_pix));
            end
            if (s_valid && s_ready) begin
                expq.push_back(embed(s_pixel, mode_r, q));
                q = mul_x(q);
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    chk("bp_unexpected_out", 32'(m_pixel), 32'hDEAD);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("bp_out%0d", n_out), 32'(m_pixel),
                        32'(e));
                end
                n_out++;
                last_out = cyc;
            end
            if (done) begin
                n_done++;
                if (!done_seen) done_cyc = cyc;
                done_seen = 1'b1;
            end
            hold = m_valid && !m_ready;
            hold_pix = m_pixel;
            @(posedge clk);
            #1;
            if (done_seen) after++;
            if (after > 4) break;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("bp_done_seen", 32'(done_seen), 32'd1);
        chk("bp_done_count", 32'(n_done), 32'd1);
        chk("bp_out_count", 32'(n_out), 32'd16);
        chk("bp_pix_cnt", 32'(pix_cnt), 32'd16);
        chk("bp_done_lat", 32'(done_cyc - last_out), 32'd1);
        chk("bp_busy_end", 32'(busy), 32'd0);

        // Single-pixel frame, zero key, start pulsed during RUN
        do_reset();
        do_start(1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b_busy_run", 32'(b_busy), 32'd1);
        chk("b_s_ready_run", 32'(b_s_ready), 32'd1);
        chk("b_pix_cnt0", 32'(b_pix_cnt), 32'd0);
        s_valid = 1'b1;
        s_pixel = 8'hA4;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("b_pixel", 32'(b_m_pixel),
            32'(embed(8'hA4, 1'b1, seed_of(8'h00))));
        chk("b_valid", 32'(b_m_valid), 32'd1);
        chk("b_s_ready_low", 32'(b_s_ready), 32'd0);
        chk("b_pix_cnt1", 32'(b_pix_cnt), 32'd1);
        chk("b_done_early", 32'(b_done), 32'd0);
        @(posedge clk);
        #1;
        chk("b_done_pulse", 32'(b_done), 32'd1);
        chk("b_valid_clr", 32'(b_m_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("b_done_end", 32'(b_done), 32'd0);
        chk("b_busy_idle", 32'(b_busy), 32'd0);
        chk("b_pix_cnt_hold", 32'(b_pix_cnt), 32'd1);

        // Reset mid-frame, then restart
        do_reset();
        do_start(1'b1);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        chk("mid_pix_cnt5", 32'(pix_cnt), 32'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_cnt", 32'(pix_cnt), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        do_start(1'b1);
        send(8'h00);
        chk("mid_first_pixel", 32'(m_pixel),
            32'(embed(8'h00, 1'b1, seed_of(8'h6A))));
        chk("mid_first_cnt", 32'(pix_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wm_embed_ctrl.md
# wm_embed_ctrl

Frame-level controller that sequences watermark embedding over a pixel stream. It seeds an internal 8-bit watermark LFSR from a key on `start` and advances the LFSR exactly once per accepted pixel. It substitutes one or two pixel LSBs with watermark bits and passes pixels downstream through a valid/ready register stage. It sits between the pixel source (frame buffer reader) and the output writer, and replaces the free-running generator wherever stalls must not desynchronise the watermark.

## Interface
- `KEY`, 8'h6A, LFSR seed; 8'h00 is illegal and is replaced by 8'h01 at seed time
- `FRAME_PIXELS`, 16'd16, pixels per frame, legal range 1..65535
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a frame; honoured only in IDLE
- `WM_select`  in  1  sampled on accepted `start`: 1 = embed 2 bits, 0 = embed 1 bit
- `s_valid`  in  1  input pixel valid
- `s_pixel`  in  8  input pixel
- `s_ready`  out  1  input accept
- `m_valid`  out  1  output pixel valid
- `m_pixel`  out  8  watermarked pixel
- `m_ready`  in  1  downstream accept
- `busy`  out  1  high in SEED, RUN, DRAIN
- `done`  out  1  one-cycle pulse at end of frame
- `pix_cnt`  out  16  pixels accepted in current frame

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE: on `start`, latch `WM_select` into `mode`, go to SEED.
- SEED: load `lfsr <= (KEY==0) ? 8'h01 : KEY`, clear `pix_cnt`, go to RUN. Lasts 1 cycle.
- LFSR next state (Galois, taps at bits 2/3/4 fed by bit 7):
  - n[0]=q[7], n[1]=q[0], n[2]=q[1]^q[7], n[3]=q[2]^q[7], n[4]=q[3]^q[7]
  - n[5]=q[4], n[6]=q[5], n[7]=q[6]
  - Advances only on an input handshake.
- Watermark bits use the current LFSR value, before advance: `w0=q[0]`, `w1=q[1]^q[0]`.
- Embedding:
  - mode=1: `m_pixel <= {s_pixel[7:2], w1, w0}`.
  - mode=0: `m_pixel <= {s_pixel[7:1], w0}`.
- RUN:
  - `s_ready = (!m_valid || m_ready) && (pix_cnt < FRAME_PIXELS)`.
  - Input handshake (`s_valid && s_ready`): load output register, set `m_valid`, increment `pix_cnt`, advance LFSR.
  - Output handshake without new input clears `m_valid`.
  - When `pix_cnt` reaches FRAME_PIXELS, go to DRAIN.
- DRAIN: `s_ready=0`. When `m_valid==0`, or on an output handshake, go to DONE with `m_valid` cleared.
- DONE: `done=1` for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `WM_select` changes mid-frame have no effect.
- Reset in any state:
  - IDLE, `m_valid=0`, `s_ready=0`, `busy=0`, `done=0`, `pix_cnt=0`, `m_pixel=0`, `lfsr=KEY`, `mode=0`.
  - The in-flight pixel is discarded.

## Timing
- `start` accepted in cycle t: SEED at t+1, `s_ready` may rise at t+2.
- Latency: input handshake in cycle t gives `m_valid`/`m_pixel` at t+1.
- Throughput is 1 pixel/cycle while `m_ready=1`.
- Simultaneous input and output handshakes in RUN: output register reloads, `m_valid` stays 1, no bubble.
- `m_ready=0` with `m_valid=1`: `s_ready=0`, `m_pixel` held stable, LFSR frozen.
- `m_valid` asserted must not drop and `m_pixel` must not change until handshake (except reset).
- Last pixel: `pix_cnt` reads FRAME_PIXELS the cycle after its handshake. `done` is asserted 1 cycle after the last output handshake (DRAIN→DONE).
- `pix_cnt` holds its final value through IDLE until the next SEED.

## Test plan
- Reset defaults: hold `rst_n=0` 3 cycles with `start=1` → all outputs 0, state IDLE; release → IDLE until a fresh `start`.
- Sequence: KEY=8'h6A, mode=1, `m_ready=1`, inputs 8'h00, 8'hFF, 8'h00 → `m_pixel` = 8'h02, 8'hFC, 8'h03. LFSR steps 6A→D4→B5.
- Mode 0: same key, inputs 8'hFF, 8'hFF, 8'hFF → 8'hFE, 8'hFE, 8'hFF. Bit 1 passes through unchanged.
- Backpressure: toggle `m_ready` 0/1 randomly across 16 pixels → output sequence identical to the `m_ready=1` run. `m_pixel` stable while stalled. `pix_cnt`=16, exactly one `done` pulse.
- Boundary: FRAME_PIXELS=1, KEY=8'h00 → seed 8'h01, single output `{s_pixel[7:2],1,1}`. `s_ready` low after the first accept. `start` pulsed during RUN is ignored.
- Reset mid-frame after 5 pixels, then `start` → LFSR restarts from KEY, `pix_cnt` from 0, first output matches the first output of the sequence test.
